// File: rtl/sq_pkg.sv
// +----------------------------------------------------------------------------+
// | sq_pkg : shared types and defaults for the sum-of-squares controller      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package sq_pkg;

    localparam int ACC_W_DEFAULT = 12;
    localparam int DATA_W        = 4;
    localparam int SQ_W          = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/square_4bit.sv
// +----------------------------------------------------------------------------+
// | square_4bit : combinational 4-bit unsigned squarer (8-bit result)         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module square_4bit
    import sq_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    output logic [SQ_W-1:0]   y
);

    logic [SQ_W-1:0] a_ext;

    // Operands widened first so the product keeps all 8 bits.
    assign a_ext = {{(SQ_W-DATA_W){1'b0}}, a};
    assign y     = a_ext * a_ext;

endmodule

`default_nettype wire

// File: rtl/sq_accum_ctrl.sv
// +----------------------------------------------------------------------------+
// | sq_accum_ctrl : runs of 1..16 samples, squares each and accumulates sum   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sq_accum_ctrl
    import sq_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        len,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [3:0]        in_data,
    output logic              in_ready,
    output logic              sq_valid,
    output logic [7:0]        sq_out,
    output logic [ACC_W-1:0]  sum,
    output logic              busy,
    output logic              done
);

    state_t      state;
    logic [3:0]  run_len;
    logic [3:0]  sample_cnt;
    logic [7:0]  square;
    logic        accept;

    square_4bit u_square (
        .a (in_data),
        .y (square)
    );

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            run_len    <= 4'd0;
            sample_cnt <= 4'd0;
            sum        <= '0;
            sq_out     <= 8'd0;
            sq_valid   <= 1'b0;
            done       <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sq_valid <= 1'b0;
            done     <= 1'b0;
            // Abort has priority over any start or sample in the same cycle.
            if (clear) begin
                state      <= IDLE;
                sample_cnt <= 4'd0;
                sum        <= '0;
                in_ready   <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state      <= RUN;
                            run_len    <= len;
                            sample_cnt <= 4'd0;
                            sum        <= '0;
                            in_ready   <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            sum        <= sum + ACC_W'(square);
                            sq_out     <= square;
                            sq_valid   <= 1'b1;
                            sample_cnt <= sample_cnt + 4'd1;
                            if (sample_cnt == run_len) begin
                                state    <= DONE;
                                in_ready <= 1'b0;
                                done     <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sq_accum_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_sq_accum_ctrl : scoreboard bench for the sum-of-squares controller     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sq_accum_ctrl;

    localparam int ACC_W = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       len;
    logic             clear;
    logic             in_valid;
    logic [3:0]       in_data;
    logic             in_ready;
    logic             sq_valid;
    logic [7:0]       sq_out;
    logic [ACC_W-1:0] sum;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int exp_sq[$];
    int exp_sum[$];

    sq_accum_ctrl #(.ACC_W(ACC_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .sq_valid (sq_valid),
        .sq_out   (sq_out),
        .sum      (sum),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Output monitor: every square and every done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (sq_valid) begin
                if (exp_sq.size() == 0) check("sq_unexpected", {31'd0, sq_valid}, 32'd0);
                else                    check("sq_out", {24'd0, sq_out}, exp_sq.pop_front());
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                if (exp_sum.size() == 0) check("done_unexpected", {31'd0, done}, 32'd0);
                else                     check("sum_final", {20'd0, sum}, exp_sum.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        check("busy_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic send(input logic [3:0] d, input int gap);
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = d;
        exp_sq.push_back(int'(d) * int'(d));
        @(negedge clk);
        check("ready_run", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run(input logic [3:0] l, input int samples[$], input int max_gap);
        int total = 0;
        foreach (samples[i]) total += samples[i] * samples[i];
        exp_sum.push_back(total);
        do_start(l);
        foreach (samples[i]) send(4'(samples[i]), $urandom_range(0, max_gap));
        check("busy_done", {31'd0, busy}, 32'd1);
        check("ready_done", {31'd0, in_ready}, 32'd0);
        tick();
    endtask

    initial begin
        int s[$];
        int dc;
        rst_n = 1'b0; start = 1'b0; len = 4'd0; clear = 1'b0;
        in_valid = 1'b0; in_data = 4'd0;
        #1;
        check("rst_sum", {20'd0, sum}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Four back-to-back maximum samples.
        s = '{15, 15, 15, 15};
        dc = done_cnt;
        run(4'd3, s, 0);
        tick();
        check("sum_hold", {20'd0, sum}, 32'd900);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("done_once_a", done_cnt, dc + 1);

        // Sixteen samples with random stalls.
        s = {};
        for (int i = 0; i < 16; i++) s.push_back(15);
        dc = done_cnt;
        run(4'd15, s, 3);
        tick();
        check("done_once_b", done_cnt, dc + 1);

        // Single sample: sq_valid must be a one-cycle pulse.
        exp_sum.push_back(49);
        do_start(4'd0);
        send(4'd7, 0);
        tick();
        check("sq_valid_pulse", {31'd0, sq_valid}, 32'd0);
        tick();

        // Start pulsed mid-run with a different len is ignored.
        exp_sum.push_back(1 + 4 + 9 + 16);
        dc = done_cnt;
        do_start(4'd3);
        send(4'd1, 0);
        start = 1'b1; len = 4'd0;
        send(4'd2, 1);
        start = 1'b0;
        send(4'd3, 0);
        check("still_run", {31'd0, busy & in_ready}, 32'd1);
        send(4'd4, 2);
        tick();
        check("done_once_c", done_cnt, dc + 1);

        // Clear together with the second accept.
        dc = done_cnt;
        do_start(4'd3);
        send(4'd5, 0);
        clear = 1'b1; in_valid = 1'b1; in_data = 4'd6;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_ready", {31'd0, in_ready}, 32'd0);
        check("clr_sum", {20'd0, sum}, 32'd0);
        check("clr_sqv", {31'd0, sq_valid}, 32'd0);
        repeat (4) tick();
        check("clr_no_done", done_cnt, dc);

        // Asynchronous reset in the middle of a run.
        dc = done_cnt;
        do_start(4'd3);
        send(4'd2, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sum", {20'd0, sum}, 32'd0);
        check("arst_sq", {24'd0, sq_out}, 32'd0);
        check("arst_sqv", {31'd0, sq_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ready", {31'd0, in_ready}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) tick();
        check("arst_no_done", done_cnt, dc);
        check("arst_idle", {31'd0, busy}, 32'd0);
        s = '{9};
        run(4'd0, s, 0);
        tick();
        check("done_once_d", done_cnt, dc + 1);
        check("sum_81", {20'd0, sum}, 32'd81);

        check("sq_left", exp_sq.size(), 32'd0);
        check("sum_left", exp_sum.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
